// File: rtl/uart_fifo_tx.sv
// Purpose: UART transmit byte FIFO with a drain FSM that feeds the TX serializer (start/done handshake).
// Latency: a write at edge N into an empty FIFO is popped at N+1; tx_start_o is high in the cycle after N+1.
// Backpressure: writes while full are dropped and flagged on overflow_o; pops wait for tx_en_i and tx_done_i.
// Optional feature: define UART_FIFO_TX_FLUSH_EN to add the flush_i input.
module uart_fifo_tx #(
    parameter int DEPTH = 8,
    parameter int DW    = 8,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          wr_en_i,
    input  logic [DW-1:0] data_i,
    input  logic          tx_en_i,
    input  logic [AW:0]   thresh_i,
    input  logic          tx_done_i,
`ifdef UART_FIFO_TX_FLUSH_EN
    input  logic          flush_i,
`endif
    output logic          tx_start_o,
    output logic [DW-1:0] tx_data_o,
    output logic          busy_o,
    output logic          full_o,
    output logic          empty_o,
    output logic [AW:0]   count_o,
    output logic          intr_lvl_o,
    output logic          overflow_o
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_WAIT  = 2'd2
    } state_t;

    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    state_t          state;
    logic [DW-1:0]   mem [DEPTH];
    logic [AW-1:0]   wr_ptr;
    logic [AW-1:0]   rd_ptr;
    logic [AW:0]     count;
    logic            flush;
    logic            push;
    logic            pop;

`ifdef UART_FIFO_TX_FLUSH_EN
    assign flush = flush_i;
`else
    assign flush = 1'b0;
`endif

    // Full/empty come from the registered counter, so a push into an empty FIFO
    // cannot be popped in the same cycle and a write while full is always rejected.
    assign full_o     = (count == FULL_CNT);
    assign empty_o    = (count == '0);
    assign count_o    = count;
    assign intr_lvl_o = (count <= thresh_i);
    assign busy_o     = (state != ST_IDLE);
    assign tx_start_o = (state == ST_START);

    // A flush wins over both a same-cycle write and a same-cycle pop from IDLE.
    assign push = wr_en_i && !full_o && !flush;
    assign pop  = (state == ST_IDLE) && tx_en_i && !empty_o && !flush;

    // Storage array; contents are intentionally left unreset.
    always_ff @(posedge clk_i) begin
        if (!rst_i && push) begin
            mem[wr_ptr] <= data_i;
        end
    end

    // Pointers, occupancy counter, overflow pulse and the drain FSM.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            overflow_o <= 1'b0;
            tx_data_o  <= '0;
            state      <= ST_IDLE;
        end else begin
            overflow_o <= wr_en_i && full_o && !flush;

            if (flush) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
                count  <= '0;
            end else begin
                if (push) begin
                    wr_ptr <= wr_ptr + 1'b1;
                end
                if (pop) begin
                    rd_ptr <= rd_ptr + 1'b1;
                end
                case ({push, pop})
                    2'b10:   count <= count + 1'b1;
                    2'b01:   count <= count - 1'b1;
                    default: count <= count;
                endcase
            end

            // A byte already in flight always finishes START/WAIT, even across a flush.
            case (state)
                ST_IDLE: begin
                    if (pop) begin
                        tx_data_o <= mem[rd_ptr];
                        state     <= ST_START;
                    end
                end
                ST_START: begin
                    state <= ST_WAIT;
                end
                ST_WAIT: begin
                    if (tx_done_i) begin
                        state <= ST_IDLE;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_fifo_tx.sv
// Directed bench for uart_fifo_tx: each task drives one scenario and checks
// outputs #1 after the rising edge against hand-computed values.
module tb_uart_fifo_tx;

    logic       clk_i = 1'b0;
    logic       rst_i;
    logic       wr_en_i;
    logic [7:0] data_i;
    logic       tx_en_i;
    logic [3:0] thresh_i;
    logic       tx_done_i;
`ifdef UART_FIFO_TX_FLUSH_EN
    logic       flush_i;
`endif
    logic       tx_start_o;
    logic [7:0] tx_data_o;
    logic       busy_o;
    logic       full_o;
    logic       empty_o;
    logic [3:0] count_o;
    logic       intr_lvl_o;
    logic       overflow_o;

    int n_checks = 0;
    int n_fail   = 0;

    uart_fifo_tx #(.DEPTH(8), .DW(8)) dut (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .wr_en_i    (wr_en_i),
        .data_i     (data_i),
        .tx_en_i    (tx_en_i),
        .thresh_i   (thresh_i),
        .tx_done_i  (tx_done_i),
`ifdef UART_FIFO_TX_FLUSH_EN
        .flush_i    (flush_i),
`endif
        .tx_start_o (tx_start_o),
        .tx_data_o  (tx_data_o),
        .busy_o     (busy_o),
        .full_o     (full_o),
        .empty_o    (empty_o),
        .count_o    (count_o),
        .intr_lvl_o (intr_lvl_o),
        .overflow_o (overflow_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic tick;
        @(posedge clk_i);
        #1;
    endtask

    // Waits (bounded) for a tx_start_o pulse; the caller judges ok and the byte.
    task automatic wait_start(input int budget, output bit ok, output logic [7:0] d);
        ok = 1'b0;
        d  = 8'h00;
        for (int i = 0; i < budget && !ok; i++) begin
            if (tx_start_o === 1'b1) begin
                ok = 1'b1;
                d  = tx_data_o;
            end else begin
                tick();
            end
        end
    endtask

    task automatic test_reset;
        rst_i = 1'b1; wr_en_i = 1'b0; data_i = 8'h00; tx_en_i = 1'b0;
        thresh_i = 4'd0; tx_done_i = 1'b0;
`ifdef UART_FIFO_TX_FLUSH_EN
        flush_i = 1'b0;
`endif
        tick(); tick();
        rst_i = 1'b0;
        n_checks++; if (count_o !== 4'd0) begin n_fail++; $display("FAIL reset_count got %0d want 0", count_o); end
        n_checks++; if (empty_o !== 1'b1) begin n_fail++; $display("FAIL reset_empty got %b want 1", empty_o); end
        n_checks++; if (full_o !== 1'b0) begin n_fail++; $display("FAIL reset_full got %b want 0", full_o); end
        n_checks++; if (busy_o !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %b want 0", busy_o); end
        n_checks++; if (tx_start_o !== 1'b0) begin n_fail++; $display("FAIL reset_start got %b want 0", tx_start_o); end
        n_checks++; if (overflow_o !== 1'b0) begin n_fail++; $display("FAIL reset_ovf got %b want 0", overflow_o); end
        n_checks++; if (tx_data_o !== 8'h00) begin n_fail++; $display("FAIL reset_data got %h want 00", tx_data_o); end
        n_checks++; if (intr_lvl_o !== 1'b1) begin n_fail++; $display("FAIL reset_intr got %b want 1", intr_lvl_o); end
    endtask

    task automatic test_hold_disabled;
        bit seen = 1'b0;
        tx_en_i = 1'b0;
        wr_en_i = 1'b1; data_i = 8'hA5; tick(); seen |= tx_start_o;
        data_i = 8'h3C; tick(); seen |= tx_start_o;
        wr_en_i = 1'b0;
        for (int i = 0; i < 4; i++) begin tick(); seen |= tx_start_o; end
        n_checks++; if (count_o !== 4'd2) begin n_fail++; $display("FAIL hold_count got %0d want 2", count_o); end
        n_checks++; if (empty_o !== 1'b0) begin n_fail++; $display("FAIL hold_empty got %b want 0", empty_o); end
        n_checks++; if (seen !== 1'b0) begin n_fail++; $display("FAIL hold_no_start got %b want 0", seen); end
    endtask

    task automatic test_drain;
        bit seen = 1'b0;
        tx_en_i = 1'b1;
        tick();
        n_checks++; if (tx_start_o !== 1'b1) begin n_fail++; $display("FAIL drain_start1 got %b want 1", tx_start_o); end
        n_checks++; if (tx_data_o !== 8'hA5) begin n_fail++; $display("FAIL drain_data1 got %h want a5", tx_data_o); end
        n_checks++; if (count_o !== 4'd1) begin n_fail++; $display("FAIL drain_count1 got %0d want 1", count_o); end
        n_checks++; if (busy_o !== 1'b1) begin n_fail++; $display("FAIL drain_busy got %b want 1", busy_o); end
        for (int i = 0; i < 10; i++) begin tick(); seen |= tx_start_o; end
        n_checks++; if (seen !== 1'b0) begin n_fail++; $display("FAIL drain_single_pulse got %b want 0", seen); end
        tx_done_i = 1'b1; tick(); tx_done_i = 1'b0;
        n_checks++; if (tx_start_o !== 1'b0) begin n_fail++; $display("FAIL drain_gap got %b want 0", tx_start_o); end
        tick();
        n_checks++; if (tx_start_o !== 1'b1) begin n_fail++; $display("FAIL drain_start2 got %b want 1", tx_start_o); end
        n_checks++; if (tx_data_o !== 8'h3C) begin n_fail++; $display("FAIL drain_data2 got %h want 3c", tx_data_o); end
        tick(); tx_done_i = 1'b1; tick(); tx_done_i = 1'b0;
        tx_en_i = 1'b0;
        n_checks++; if (busy_o !== 1'b0) begin n_fail++; $display("FAIL drain_idle got %b want 0", busy_o); end
    endtask

    task automatic test_overflow;
        bit ok;
        logic [7:0] d;
        tx_en_i = 1'b0;
        wr_en_i = 1'b1;
        for (int i = 0; i < 8; i++) begin data_i = 8'(i); tick(); end
        n_checks++; if (full_o !== 1'b1) begin n_fail++; $display("FAIL ovf_full got %b want 1", full_o); end
        data_i = 8'hFF; tick(); wr_en_i = 1'b0;
        n_checks++; if (overflow_o !== 1'b1) begin n_fail++; $display("FAIL ovf_pulse got %b want 1", overflow_o); end
        n_checks++; if (count_o !== 4'd8) begin n_fail++; $display("FAIL ovf_count got %0d want 8", count_o); end
        tick();
        n_checks++; if (overflow_o !== 1'b0) begin n_fail++; $display("FAIL ovf_one_cycle got %b want 0", overflow_o); end
        tx_en_i = 1'b1;
        for (int i = 0; i < 8; i++) begin
            wait_start(20, ok, d);
            n_checks++; if (ok !== 1'b1 || d !== 8'(i)) begin n_fail++; $display("FAIL ovf_order[%0d] got ok=%b %h want ok=1 %h", i, ok, d, 8'(i)); end
            tick(); tx_done_i = 1'b1; tick(); tx_done_i = 1'b0;
        end
        wait_start(10, ok, d);
        n_checks++; if (ok !== 1'b0) begin n_fail++; $display("FAIL ovf_dropped_sent got %b (%h) want 0", ok, d); end
        tx_en_i = 1'b0;
    endtask

    task automatic test_stream;
        int next_wr = 0;
        int next_rd = 0;
        int dly = 0;
        int cyc = 0;
        tx_en_i = 1'b0;
        wr_en_i = 1'b1;
        data_i = 8'h10; tick(); data_i = 8'h11; tick();
        // Simultaneous push and pop
        data_i = 8'h12; tx_en_i = 1'b1; tick();
        wr_en_i = 1'b0;
        n_checks++; if (count_o !== 4'd2) begin n_fail++; $display("FAIL stream_pushpop_count got %0d want 2", count_o); end
        n_checks++; if (tx_start_o !== 1'b1 || tx_data_o !== 8'h10) begin n_fail++; $display("FAIL stream_first got start=%b %h want 1 10", tx_start_o, tx_data_o); end
        next_wr = 3; next_rd = 1; dly = 2;
        while ((next_rd < 20 || dly != 0) && cyc < 400) begin
            wr_en_i = (next_wr < 20) && (cyc % 2 == 0) && !full_o;
            data_i = 8'(8'h10 + next_wr);
            if (wr_en_i) next_wr++;
            tx_done_i = (dly == 1);
            if (dly > 0) dly--;
            tick();
            cyc++;
            if (tx_start_o === 1'b1) begin
                n_checks++; if (tx_data_o !== 8'(8'h10 + next_rd)) begin n_fail++; $display("FAIL stream_order[%0d] got %h want %h", next_rd, tx_data_o, 8'(8'h10 + next_rd)); end
                next_rd++;
                dly = 2;
            end
        end
        wr_en_i = 1'b0; tx_done_i = 1'b0; tx_en_i = 1'b0;
        n_checks++; if (next_rd !== 20) begin n_fail++; $display("FAIL stream_total got %0d want 20", next_rd); end
        n_checks++; if (count_o !== 4'd0 || busy_o !== 1'b0) begin n_fail++; $display("FAIL stream_end got count=%0d busy=%b want 0 0", count_o, busy_o); end
    endtask

    task automatic test_thresh;
        thresh_i = 4'd2; tx_en_i = 1'b0;
        wr_en_i = 1'b1;
        data_i = 8'h41; tick(); data_i = 8'h42; tick(); data_i = 8'h43; tick();
        wr_en_i = 1'b0;
        n_checks++; if (intr_lvl_o !== 1'b0) begin n_fail++; $display("FAIL thresh_above got %b want 0", intr_lvl_o); end
        tx_en_i = 1'b1; tick(); tx_en_i = 1'b0;
        n_checks++; if (count_o !== 4'd2 || intr_lvl_o !== 1'b1) begin n_fail++; $display("FAIL thresh_at got count=%0d intr=%b want 2 1", count_o, intr_lvl_o); end
        n_checks++; if (tx_data_o !== 8'h41) begin n_fail++; $display("FAIL thresh_data got %h want 41", tx_data_o); end
        tick(); tx_done_i = 1'b1; tick(); tx_done_i = 1'b0;
        n_checks++; if (busy_o !== 1'b0 || count_o !== 4'd2) begin n_fail++; $display("FAIL thresh_txen_low got busy=%b count=%0d want 0 2", busy_o, count_o); end
    endtask

    task automatic test_reset_midframe;
        bit seen = 1'b0;
        wr_en_i = 1'b1;
        data_i = 8'h44; tick(); data_i = 8'h45; tick();
        wr_en_i = 1'b0;
        tx_en_i = 1'b1; tick(); tx_en_i = 1'b0; tick();
        n_checks++; if (busy_o !== 1'b1 || count_o !== 4'd3) begin n_fail++; $display("FAIL rstmid_pre got busy=%b count=%0d want 1 3", busy_o, count_o); end
        rst_i = 1'b1; tick(); rst_i = 1'b0;
        n_checks++; if (busy_o !== 1'b0 || count_o !== 4'd0 || empty_o !== 1'b1) begin n_fail++; $display("FAIL rstmid_post got busy=%b count=%0d empty=%b want 0 0 1", busy_o, count_o, empty_o); end
        tx_done_i = 1'b1; tick(); seen |= tx_start_o; tx_done_i = 1'b0;
        tx_en_i = 1'b1;
        for (int i = 0; i < 4; i++) begin tick(); seen |= tx_start_o; end
        tx_en_i = 1'b0;
        n_checks++; if (seen !== 1'b0) begin n_fail++; $display("FAIL rstmid_no_start got %b want 0", seen); end
    endtask

`ifdef UART_FIFO_TX_FLUSH_EN
    task automatic test_flush;
        bit seen = 1'b0;
        wr_en_i = 1'b1;
        data_i = 8'h51; tick(); data_i = 8'h52; tick(); data_i = 8'h53; tick();
        wr_en_i = 1'b0;
        tx_en_i = 1'b1; tick(); tx_en_i = 1'b0; tick();
        flush_i = 1'b1; wr_en_i = 1'b1; data_i = 8'h99; tick();
        flush_i = 1'b0; wr_en_i = 1'b0;
        n_checks++; if (count_o !== 4'd0 || busy_o !== 1'b1) begin n_fail++; $display("FAIL flush_state got count=%0d busy=%b want 0 1", count_o, busy_o); end
        n_checks++; if (overflow_o !== 1'b0 || tx_data_o !== 8'h51) begin n_fail++; $display("FAIL flush_side got ovf=%b data=%h want 0 51", overflow_o, tx_data_o); end
        tx_done_i = 1'b1; tick(); tx_done_i = 1'b0;
        n_checks++; if (busy_o !== 1'b0) begin n_fail++; $display("FAIL flush_done got %b want 0", busy_o); end
        tx_en_i = 1'b1;
        for (int i = 0; i < 4; i++) begin tick(); seen |= tx_start_o; end
        tx_en_i = 1'b0;
        n_checks++; if (seen !== 1'b0) begin n_fail++; $display("FAIL flush_no_start got %b want 0", seen); end
    endtask
`endif

    initial begin
        test_reset();
        test_hold_disabled();
        test_drain();
        test_overflow();
        test_stream();
        test_thresh();
        test_reset_midframe();
`ifdef UART_FIFO_TX_FLUSH_EN
        test_flush();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
